// File: rtl/cmd_pkg.sv
// cmd_pkg: shared definitions for the command issuer slice.
//   DATA_W / OP_W : operand and opcode widths
//   CMD_W         : width of one buffered command {op, data}
//   PUSH/POP/ADD  : opcodes that change the downstream stack depth
package cmd_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;
  localparam int CMD_W  = OP_W + DATA_W;

  localparam logic [OP_W-1:0] PUSH = 3'b101;
  localparam logic [OP_W-1:0] POP  = 3'b100;
  localparam logic [OP_W-1:0] ADD  = 3'b011;

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: circular command buffer with occupancy count.
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   wr_en      : write wr_data at the tail (caller guarantees not full)
//   wr_data    : command word
//   rd_en      : drop the head entry (caller guarantees not empty)
//   rd_data    : current head entry (combinational)
//   count      : number of buffered entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module cmd_fifo
  import cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/cmd_issuer.sv
// cmd_issuer: buffers host commands and issues them to a stack unit.
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   host_data/op      : command operand / opcode from the host
//   host_valid        : host offers a command
//   host_ready        : a command is accepted this cycle (FIFO not full)
//   hold              : suspends issue while high
//   in, op, apply     : registered operand, opcode and issue strobe
//   fifo_count        : number of buffered commands
//   err               : sticky dropped-command flag
// Optional feature: define CMD_ISSUER_DEPTH_CHECK_EN to track the stack
// depth and drop commands that would over/underflow it; otherwise every
// command is issued and err is constant 0.
module cmd_issuer
  import cmd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int STACK_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           host_data,
  input  logic [OP_W-1:0]             host_op,
  input  logic                        host_valid,
  output logic                        host_ready,
  input  logic                        hold,
  output logic [DATA_W-1:0]           in,
  output logic [OP_W-1:0]             op,
  output logic                        apply,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic             wr_en;
  logic             rd_en;
  logic [CMD_W-1:0] head;
  logic [OP_W-1:0]  head_op;
  logic [DATA_W-1:0] head_data;
  logic             drop;
  logic             issue;

  // No full-bypass: a full FIFO refuses writes even while it is popping.
  assign host_ready = (fifo_count < CW'(FIFO_DEPTH));
  assign wr_en      = host_valid && host_ready;
  assign rd_en      = (fifo_count != '0) && !hold;
  assign head_op    = head[CMD_W-1:DATA_W];
  assign head_data  = head[DATA_W-1:0];

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data ({host_op, host_data}),
    .rd_en   (rd_en),
    .rd_data (head),
    .count   (fifo_count)
  );

`ifdef CMD_ISSUER_DEPTH_CHECK_EN
  localparam int DW = $clog2(STACK_DEPTH + 1);

  logic [DW-1:0] depth;
  logic [DW-1:0] depth_nxt;

  // Depth tracks only commands actually issued; a dropped command leaves it.
  always_comb begin
    drop      = 1'b0;
    depth_nxt = depth;
    case (head_op)
      PUSH: begin
        if (depth == DW'(STACK_DEPTH)) drop = 1'b1;
        else                           depth_nxt = depth + DW'(1);
      end
      POP: begin
        if (depth == '0) drop = 1'b1;
        else             depth_nxt = depth - DW'(1);
      end
      ADD: begin
        if (depth <= DW'(1)) drop = 1'b1;
        else                 depth_nxt = depth - DW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth <= '0;
      err   <= 1'b0;
    end else if (rd_en) begin
      depth <= depth_nxt;
      if (drop) err <= 1'b1;
    end
  end
`else
  logic unused_stack_depth;

  assign unused_stack_depth = |STACK_DEPTH;
  assign drop = 1'b0;
  assign err  = 1'b0;
`endif

  assign issue = rd_en && !drop;

  // in/op only move on a real issue so they hold the last issued command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      apply <= 1'b0;
      op    <= '0;
      in    <= '0;
    end else begin
      apply <= issue;
      if (issue) begin
        op <= head_op;
        in <= head_data;
      end
    end
  end

endmodule

// File: doc/cmd_issuer.md
CMD_ISSUER -- requirements
Module: cmd_issuer

Interface
- REQ-001 SHALL provide parameter FIFO_DEPTH, default 4, meaning the number of buffered host commands (power of two, at least 2).
- REQ-002 SHALL provide parameter STACK_DEPTH, default 8, meaning the capacity of the downstream stack unit, used only by the depth check.
- REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
- REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-005 SHALL have port host_data, input, 8 bits: command operand.
- REQ-006 SHALL have port host_op, input, 3 bits: command opcode.
- REQ-007 SHALL have port host_valid, input, 1 bit: host offers a command.
- REQ-008 SHALL have port host_ready, output, 1 bit: the block accepts a command this cycle.
- REQ-009 SHALL have port hold, input, 1 bit: suspends issue while high.
- REQ-010 SHALL have port in, output, 8 bits: operand to the stack unit.
- REQ-011 SHALL have port op, output, 3 bits: opcode to the stack unit.
- REQ-012 SHALL have port apply, output, 1 bit: issue strobe to the stack unit.
- REQ-013 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: buffered command count.
- REQ-014 SHALL have port err, output, 1 bit: sticky flag for a dropped command.

Function
- REQ-015 SHALL use these opcodes: PUSH=3'b101, POP=3'b100, ADD=3'b011 (consumes two entries, pushes one). All other codes SHALL pass through with no change to depth.
- REQ-016 SHALL drive host_ready = (fifo_count < FIFO_DEPTH) combinationally. A full FIFO SHALL deassert host_ready even when an issue occurs in the same cycle (no full-bypass).
- REQ-017 SHALL write {host_op, host_data} into the FIFO tail on every cycle where host_valid && host_ready.
- REQ-018 SHALL pop the FIFO head on every cycle where fifo_count != 0 && !hold. in, op and apply SHALL be registered from that head, so apply=1 in the following cycle.
- REQ-019 SHALL take at least 2 cycles from acceptance to apply. Sustained throughput SHALL be one command per cycle.
- REQ-020 SHALL hold apply=0 in any cycle with no pop, while in and op keep their last issued values.
- REQ-021 SHALL update fifo_count by +1, -1 or 0 when a write and a pop occur together, and SHALL never exceed FIFO_DEPTH.
- REQ-022 SHALL wrap FIFO pointers modulo FIFO_DEPTH.
- REQ-023 SHALL stop a pop in the cycle hold rises. Commands already registered SHALL still complete.

Reset
- REQ-024 While rst=1: apply=0, op=3'b000, in=8'h00, fifo_count=0, err=0, FIFO pointers=0, shadow depth=0. host_ready SHALL then read 1.
- REQ-025 Reset mid-operation SHALL discard all buffered commands, and no apply SHALL occur in the first cycle after rst falls.

Configuration
- REQ-026 With CMD_ISSUER_DEPTH_CHECK_EN defined, the block SHALL keep a shadow depth counter (0..STACK_DEPTH), updated on each issue.
- REQ-027 With CMD_ISSUER_DEPTH_CHECK_EN defined, the block SHALL drop a popped command in these cases: PUSH at depth==STACK_DEPTH, POP at depth==0, ADD at depth<2.
- REQ-028 A dropped command SHALL consume its FIFO slot, leave apply=0 for that slot, and set err, which stays 1 until reset.
- REQ-029 Without CMD_ISSUER_DEPTH_CHECK_EN, every popped command SHALL be issued, no depth counter SHALL exist, and err SHALL be tied to 0.

Structure
- REQ-030 Shared package cmd_pkg SHALL hold the opcode constants PUSH, POP and ADD, the 8-bit data width, and the 3-bit opcode width.
- REQ-031 The FIFO SHALL be a sub-module cmd_fifo (storage, pointers, count). Issue registers and depth check SHALL live in cmd_issuer.

Verification
- REQ-032 Push 8'h02, 8'h04, 8'h01 on consecutive cycles, hold=0 -> apply=1 on three consecutive cycles with in=02,04,01 and op=101, the first 2 cycles after the first acceptance.
- REQ-033 hold=1, host writes 4 commands -> fifo_count=4, host_ready=0 with no writes accepted. Release hold -> 4 consecutive applies in FIFO order, and fifo_count returns to 0.
- REQ-034 Full FIFO with host_valid=1 and hold just released -> host_ready=0 that cycle; count goes 4->3, then the next write is accepted.
- REQ-035 With the macro, POP as the first command after reset -> apply stays 0 and err=1. A following PUSH 8'h06 -> apply=1, in=06, and err stays 1.
- REQ-036 With the macro, PUSH, PUSH, ADD, ADD -> three applies, the second ADD is dropped, err=1. Without the macro -> four applies and err=0.
- REQ-037 Assert rst for 1 cycle with 3 commands buffered -> fifo_count=0, apply=0 and op=000 immediately, and no stale command is issued afterwards.
